cadence_meter: RTL

Measures pedal cadence from the crank reed-switch input and produces an 8-bit RPM value plus a pedaling flag. It sits directly upstream of the assistance calculation, replacing the raw `cadence` pulse feed. The block synchronises the input, rejects contact bounce, times crank periods in milliseconds and converts each period to RPM with a sequential divider. A stall timeout forces the reading to zero.

---
 rtl/cadence_meter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cadence_meter.sv
// Crank cadence meter: synchronises and debounces the reed switch, times crank
// periods in ms and converts each period to RPM with a 16-step restoring divider.
module cadence_meter #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TIMEOUT_MS  = 3000
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        cadence,
  output logic [7:0]  cadence_rpm,
  output logic        rpm_valid,
  output logic        pedaling,
  output logic [11:0] period_ms
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = 12;
  localparam int unsigned QUO_W = 16;
  localparam int unsigned LCK_W = 8;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  // The accept cycle itself counts as the first prescaler cycle, so a period of
  // N*TICK_DIV cycles between accepted edges reads as exactly N ms.
  localparam logic [PRE_W-1:0] PRE_LOAD = (TICK_DIV > 1) ? PRE_W'(1) : PRE_W'(0);
  localparam logic [QUO_W-1:0] DIVIDEND = 16'd60000;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} stateT;

  stateT             state, stateNxt;
  logic              s1, s2, s3;
  logic [PRE_W-1:0]  prescale, prescaleNxt;
  logic [CNT_W-1:0]  periodCnt, periodCntNxt;
  logic [LCK_W-1:0]  lockCnt, lockCntNxt;
  logic [CNT_W-1:0]  divisor, divisorNxt;
  logic [QUO_W-1:0]  quo, quoNxt;
  logic [CNT_W-1:0]  rem, remNxt;
  logic [3:0]        iter, iterNxt;
  logic [7:0]        rpmNxt;
  logic              validNxt, pedalNxt;
  logic [CNT_W-1:0]  periodNxt;

  logic              rise, accept, msTick, geq;
  logic [CNT_W:0]    remShift, remSub;
  logic [QUO_W-1:0]  quoShift;

  assign rise     = s2 & ~s3;
  assign accept   = rise & (lockCnt == '0);
  assign msTick   = (prescale == PRE_LAST);
  assign remShift = {rem, quo[QUO_W-1]};
  assign geq      = (remShift >= {1'b0, divisor});
  assign remSub   = remShift - {1'b0, divisor};
  assign quoShift = {quo[QUO_W-2:0], geq};

  // Next-state, datapath and registered-output logic
  always_comb begin
    stateNxt     = state;
    prescaleNxt  = prescale;
    periodCntNxt = periodCnt;
    lockCntNxt   = lockCnt;
    divisorNxt   = divisor;
    quoNxt       = quo;
    remNxt       = rem;
    iterNxt      = iter;
    rpmNxt       = cadence_rpm;
    validNxt     = 1'b0;
    pedalNxt     = pedaling;
    periodNxt    = period_ms;

    if (accept) begin
      prescaleNxt  = PRE_LOAD;
      periodCntNxt = '0;
      lockCntNxt   = LCK_W'(DEBOUNCE_MS);
    end else begin
      prescaleNxt = msTick ? '0 : prescale + PRE_W'(1);
      if (msTick && periodCnt != CNT_MAX) periodCntNxt = periodCnt + CNT_W'(1);
      if (msTick && lockCnt != '0)        lockCntNxt   = lockCnt - LCK_W'(1);
    end

    case (state)
      IDLE: begin
        if (accept) stateNxt = MEASURE;
      end
      MEASURE: begin
        if (accept) begin
          divisorNxt = periodCnt;
          quoNxt     = DIVIDEND;
          remNxt     = '0;
          iterNxt    = '0;
          stateNxt   = DIVIDE;
        end else if (periodCnt >= CNT_W'(TIMEOUT_MS)) begin
          rpmNxt    = '0;
          periodNxt = '0;
          pedalNxt  = 1'b0;
          validNxt  = 1'b1;
          stateNxt  = IDLE;
        end
      end
      DIVIDE: begin
        remNxt  = geq ? remSub[CNT_W-1:0] : remShift[CNT_W-1:0];
        quoNxt  = quoShift;
        iterNxt = iter + 4'd1;
        if (iter == 4'd15) begin
          rpmNxt    = (divisor == '0 || quoShift[15:8] != 8'd0) ? 8'hFF : quoShift[7:0];
          periodNxt = divisor;
          pedalNxt  = 1'b1;
          validNxt  = 1'b1;
          stateNxt  = MEASURE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      prescale    <= '0;
      periodCnt   <= '0;
      lockCnt     <= '0;
      divisor     <= '0;
      quo         <= '0;
      rem         <= '0;
      iter        <= '0;
      cadence_rpm <= '0;
      rpm_valid   <= 1'b0;
      pedaling    <= 1'b0;
      period_ms   <= '0;
    end else begin
      state       <= stateNxt;
      s1          <= cadence;
      s2          <= s1;
      s3          <= s2;
      prescale    <= prescaleNxt;
      periodCnt   <= periodCntNxt;
      lockCnt     <= lockCntNxt;
      divisor     <= divisorNxt;
      quo         <= quoNxt;
      rem         <= remNxt;
      iter        <= iterNxt;
      cadence_rpm <= rpmNxt;
      rpm_valid   <= validNxt;
      pedaling    <= pedalNxt;
      period_ms   <= periodNxt;
    end
  end

  // The lockout must always outlast the divide
  noEdgeInDivide: assert property (@(posedge CLOCK_50) disable iff (!reset_n)
    (state == DIVIDE) |-> !accept);

endmodule
